// File: rtl/mastermind_round_tracker.sv
// mastermind_round_tracker
// Sits after the Mastermind compare datapath. Takes one scored guess per
// result_valid pulse, counts guesses, decides WIN/LOSE, drives the red/white
// result digits and blinks them once the game is over.
// Optional feature macro: MM_HISTORY_EN keeps a per-guess history readable
// through hist_sel. Without it the hist_* outputs are tied to zero.
module mastermind_round_tracker #(
   parameter int MAX_GUESSES = 8,
   parameter int BLINK_DIV   = 25_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       new_game,
   input  logic       result_valid,
   input  logic [2:0] red_in,
   input  logic [2:0] white_in,
   input  logic [2:0] hist_sel,
   output logic [1:0] game_state,
   output logic       accept_guess,
   output logic [3:0] guess_count,
   output logic [2:0] disp_red,
   output logic [2:0] disp_white,
   output logic       disp_blank,
   output logic       err_sticky,
   output logic [2:0] hist_red,
   output logic [2:0] hist_white,
   output logic       hist_valid
);

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      WIN  = 2'd1,
      LOSE = 2'd2
   } state_t;

   localparam int CW = $clog2(BLINK_DIV);
   localparam int IW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
   localparam logic [3:0]    MAX_CNT    = 4'(MAX_GUESSES);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] blink_cnt;
   logic          take;
   logic          bad;

   // A result is usable only if each count and their 4-bit sum stay within 0..4.
   function automatic logic well_formed(input logic [2:0] r, input logic [2:0] w);
      logic [3:0] sum;
      sum = {1'b0, r} + {1'b0, w};
      return (r <= 3'd4) && (w <= 3'd4) && (sum <= 4'd4);
   endfunction

   // new_game drops any same-cycle result; results outside PLAY are ignored.
   assign take = result_valid && !new_game && (state == PLAY) &&  well_formed(red_in, white_in);
   assign bad  = result_valid && !new_game && (state == PLAY) && !well_formed(red_in, white_in);

   assign game_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= PLAY;
      else         state <= state_next;
   end

   // Next-state decision: a 4-red result wins even on the final guess.
   always_comb begin
      state_next = state;
      if (new_game) begin
         state_next = PLAY;
      end else begin
         case (state)
            PLAY: begin
               if (take) begin
                  if (red_in == 3'd4)                       state_next = WIN;
                  else if (guess_count + 4'd1 == MAX_CNT)   state_next = LOSE;
               end
            end
            WIN:     state_next = WIN;
            LOSE:    state_next = LOSE;
            default: state_next = PLAY;
         endcase
      end
   end

   // accept_guess is registered alongside the state it decodes.
   always_ff @(posedge clk) begin
      if (!resetn) accept_guess <= 1'b1;
      else         accept_guess <= (state_next == PLAY);
   end

   // Guess counter, displayed result and malformed-result flag.
   always_ff @(posedge clk) begin
      if (!resetn || new_game) begin
         guess_count <= 4'd0;
         disp_red    <= 3'd0;
         disp_white  <= 3'd0;
         err_sticky  <= 1'b0;
      end else begin
         if (take) begin
            if (guess_count < MAX_CNT) guess_count <= guess_count + 4'd1;
            disp_red   <= red_in;
            disp_white <= white_in;
         end
         if (bad) err_sticky <= 1'b1;
      end
   end

   // Blink divider: idle at zero during PLAY, toggles disp_blank on every wrap.
   always_ff @(posedge clk) begin
      if (!resetn || new_game || (state == PLAY)) begin
         blink_cnt  <= '0;
         disp_blank <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt  <= '0;
         disp_blank <= ~disp_blank;
      end else begin
         blink_cnt  <= blink_cnt + 1'b1;
      end
   end

`ifdef MM_HISTORY_EN
   logic [5:0]             hist_mem [MAX_GUESSES];
   logic [MAX_GUESSES-1:0] hist_vld;
   logic [IW-1:0]          wr_idx;
   logic [IW-1:0]          rd_idx;

   // guess_count is always below MAX_GUESSES while a result is taken.
   assign wr_idx = guess_count[IW-1:0];
   assign rd_idx = hist_sel[IW-1:0];

   // Valid bits are cleared at the start of every game.
   always_ff @(posedge clk) begin
      if (!resetn || new_game) hist_vld <= '0;
      else if (take)           hist_vld[wr_idx] <= 1'b1;
   end

   // Entry payload needs no reset; the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (take) hist_mem[wr_idx] <= {red_in, white_in};
   end

   // Combinational read; unwritten or out-of-range entries read as zero.
   always_comb begin
      hist_valid = 1'b0;
      hist_red   = 3'd0;
      hist_white = 3'd0;
      if (int'(hist_sel) < MAX_GUESSES) begin
         hist_valid = hist_vld[rd_idx];
         if (hist_vld[rd_idx]) begin
            hist_red   = hist_mem[rd_idx][5:3];
            hist_white = hist_mem[rd_idx][2:0];
         end
      end
   end
`else
   logic unused_hist_sel;

   assign unused_hist_sel = ^hist_sel;
   assign hist_valid      = 1'b0;
   assign hist_red        = 3'd0;
   assign hist_white      = 3'd0;
`endif

endmodule

// File: tb/tb_mastermind_round_tracker.sv
// Bench for mastermind_round_tracker (MAX_GUESSES=8, BLINK_DIV=4).
// Stimulus tasks push expected register values into a scoreboard queue;
// a monitor pops and compares them one cycle later.
module tb_mastermind_round_tracker;

   localparam int MAXG  = 8;
   localparam int BLINK = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       new_game = 1'b0;
   logic       result_valid = 1'b0;
   logic [2:0] red_in = 3'd0;
   logic [2:0] white_in = 3'd0;
   logic [2:0] hist_sel = 3'd0;
   logic [1:0] game_state;
   logic       accept_guess;
   logic [3:0] guess_count;
   logic [2:0] disp_red;
   logic [2:0] disp_white;
   logic       disp_blank;
   logic       err_sticky;
   logic [2:0] hist_red;
   logic [2:0] hist_white;
   logic       hist_valid;

   int checks = 0;
   int errors = 0;

   mastermind_round_tracker #(.MAX_GUESSES(MAXG), .BLINK_DIV(BLINK)) dut (
      .clk(clk), .resetn(resetn), .new_game(new_game), .result_valid(result_valid),
      .red_in(red_in), .white_in(white_in), .hist_sel(hist_sel),
      .game_state(game_state), .accept_guess(accept_guess), .guess_count(guess_count),
      .disp_red(disp_red), .disp_white(disp_white), .disp_blank(disp_blank),
      .err_sticky(err_sticky), .hist_red(hist_red), .hist_white(hist_white),
      .hist_valid(hist_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] st;
      logic       acc;
      logic [3:0] cnt;
      logic [2:0] r;
      logic [2:0] w;
      logic       blank;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   // reference model of the registered state
   int m_st = 0, m_cnt = 0, m_r = 0, m_w = 0, m_blank = 0, m_err = 0, m_bcnt = 0;
   int h_r[MAXG];
   int h_w[MAXG];
   bit h_v[MAXG];

   task automatic model_clear();
      m_st = 0; m_cnt = 0; m_r = 0; m_w = 0; m_blank = 0; m_err = 0; m_bcnt = 0;
      for (int i = 0; i < MAXG; i++) begin h_v[i] = 0; h_r[i] = 0; h_w[i] = 0; end
   endtask

   // one clock of stimulus; model advanced and expectation queued
   task automatic drive(input bit rn, input bit ng, input bit rv, input int r, input int w);
      exp_t x;
      @(negedge clk);
      resetn = rn; new_game = ng; result_valid = rv;
      red_in = 3'(r); white_in = 3'(w);
      if (!rn || ng) begin
         model_clear();
      end else if (m_st == 0) begin
         if (rv) begin
            if (r > 4 || w > 4 || r + w > 4) begin
               m_err = 1;
            end else begin
               h_v[m_cnt] = 1; h_r[m_cnt] = r; h_w[m_cnt] = w;
               m_cnt = m_cnt + 1; m_r = r; m_w = w;
               if (r == 4) m_st = 1;
               else if (m_cnt == MAXG) m_st = 2;
            end
         end
      end else begin
         if (m_bcnt == BLINK - 1) begin m_bcnt = 0; m_blank = 1 - m_blank; end
         else m_bcnt = m_bcnt + 1;
      end
      x.st = 2'(m_st); x.acc = (m_st == 0); x.cnt = 4'(m_cnt);
      x.r = 3'(m_r); x.w = 3'(m_w); x.blank = 1'(m_blank); x.err = 1'(m_err);
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
   endtask

   // scoreboard consumer
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (game_state !== e.st) begin errors++; $display("FAIL game_state: got %0d want %0d @%0t", game_state, e.st, $time); end
         checks++;
         if (accept_guess !== e.acc) begin errors++; $display("FAIL accept_guess: got %0b want %0b @%0t", accept_guess, e.acc, $time); end
         checks++;
         if (guess_count !== e.cnt) begin errors++; $display("FAIL guess_count: got %0d want %0d @%0t", guess_count, e.cnt, $time); end
         checks++;
         if (disp_red !== e.r || disp_white !== e.w) begin errors++; $display("FAIL disp: got %0d/%0d want %0d/%0d @%0t", disp_red, disp_white, e.r, e.w, $time); end
         checks++;
         if (disp_blank !== e.blank) begin errors++; $display("FAIL disp_blank: got %0b want %0b @%0t", disp_blank, e.blank, $time); end
         checks++;
         if (err_sticky !== e.err) begin errors++; $display("FAIL err_sticky: got %0b want %0b @%0t", err_sticky, e.err, $time); end
      end
   end

   task automatic test_reset();
      drive(0, 0, 0, 0, 0);
      drive(0, 1, 1, 2, 1);
      idle(1);
   endtask

   task automatic test_first_guess();
      drive(1, 0, 1, 1, 2);
      idle(1);
      checks++;
      if (guess_count !== 4'd1 || disp_red !== 3'd1 || disp_white !== 3'd2 || accept_guess !== 1'b1)
      begin errors++; $display("FAIL first_guess: got cnt=%0d disp=%0d/%0d acc=%0b want 1 1/2 1", guess_count, disp_red, disp_white, accept_guess); end
   endtask

   task automatic test_win();
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      drive(1, 0, 1, 2, 1);
      drive(1, 0, 1, 4, 0);
      drive(1, 0, 1, 1, 1);
      drive(1, 0, 1, 7, 7);
      idle(13);
      checks++;
      if (game_state !== 2'd1 || guess_count !== 4'd3 || err_sticky !== 1'b0)
      begin errors++; $display("FAIL win_hold: got st=%0d cnt=%0d err=%0b want 1 3 0", game_state, guess_count, err_sticky); end
   endtask

   task automatic test_lose();
      drive(1, 1, 0, 0, 0);
      for (int i = 0; i < MAXG + 1; i++) drive(1, 0, 1, 3, 0);
      idle(6);
      checks++;
      if (game_state !== 2'd2 || guess_count !== 4'd8)
      begin errors++; $display("FAIL lose: got st=%0d cnt=%0d want 2 8", game_state, guess_count); end
      drive(1, 1, 0, 0, 0);
      idle(2);
   endtask

   task automatic test_malformed();
      drive(1, 0, 1, 1, 0);
      drive(1, 0, 1, 3, 3);
      drive(1, 0, 1, 5, 0);
      drive(1, 0, 1, 0, 5);
      drive(1, 0, 1, 4, 1);
      drive(1, 0, 1, 7, 7);
      drive(1, 0, 1, 2, 2);
      idle(1);
      checks++;
      if (err_sticky !== 1'b1 || guess_count !== 4'd2 || disp_red !== 3'd2 || disp_white !== 3'd2)
      begin errors++; $display("FAIL malformed: got err=%0b cnt=%0d disp=%0d/%0d want 1 2 2/2", err_sticky, guess_count, disp_red, disp_white); end
      drive(1, 1, 0, 0, 0);
      idle(1);
   endtask

   task automatic test_collision();
      drive(1, 0, 1, 1, 0);
      drive(1, 1, 1, 3, 1);
      drive(1, 1, 1, 6, 6);
      idle(1);
      checks++;
      if (guess_count !== 4'd0 || disp_red !== 3'd0 || err_sticky !== 1'b0)
      begin errors++; $display("FAIL collision: got cnt=%0d red=%0d err=%0b want 0 0 0", guess_count, disp_red, err_sticky); end
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 1, 2, 0);
      drive(1, 0, 1, 4, 0);
      idle(2);
      drive(0, 1, 1, 1, 1);
      drive(0, 0, 1, 1, 1);
      idle(1);
   endtask

   task automatic test_history();
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 1, 1);
      drive(1, 0, 1, 2, 0);
      idle(2);
      for (int s = 0; s < 8; s++) begin
         hist_sel = 3'(s);
         #1;
         checks++;
`ifdef MM_HISTORY_EN
         if (hist_valid !== h_v[s] || hist_red !== 3'(h_r[s]) || hist_white !== 3'(h_w[s]))
         begin errors++; $display("FAIL hist sel=%0d: got %0d/%0d v=%0b want %0d/%0d v=%0b", s, hist_red, hist_white, hist_valid, h_r[s], h_w[s], h_v[s]); end
`else
         if (hist_valid !== 1'b0 || hist_red !== 3'd0 || hist_white !== 3'd0)
         begin errors++; $display("FAIL hist_off sel=%0d: got %0d/%0d v=%0b want 0/0 v=0", s, hist_red, hist_white, hist_valid); end
`endif
      end
      drive(1, 1, 0, 0, 0);
      idle(1);
      hist_sel = 3'd7;
      #1;
      checks++;
      if (hist_valid !== 1'b0)
      begin errors++; $display("FAIL hist_clear sel=7: got v=%0b want v=0", hist_valid); end
      hist_sel = 3'd0;
      #1;
      checks++;
      if (hist_valid !== 1'b0)
      begin errors++; $display("FAIL hist_clear sel=0: got v=%0b want v=0", hist_valid); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_first_guess();
      test_win();
      test_lose();
      test_malformed();
      test_collision();
      test_reset_mid();
      test_history();
      idle(1);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL drain: got %0d pending want 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
